alu_seq_top: RTL

- Next-generation parametrised ALU with a single registered result bus and a valid/ready input handshake.
- Single-cycle ops: add, sub, logic, compare, barrel shift.
- Multi-cycle iterative ops: unsigned shift-add multiply and restoring divide.
- Also provides status flags. Sits between the operand register file and the writeback stage.

---
 rtl/alu_seq_top.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_top.sv
// Parametrised ALU: single-cycle add/sub/logic/compare/shift ops plus iterative
// shift-add multiply and restoring divide behind a valid/ready input handshake.
module alu_seq_top #(
    parameter int Op_Width = 16,
    parameter int Sh_Width = $clog2(Op_Width)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [Op_Width-1:0] A,
    input  logic [Op_Width-1:0] B,
    input  logic [3:0]          ALU_FUN,
    input  logic                IN_VALID,
    output logic                IN_READY,
    output logic [Op_Width-1:0] RESULT,
    output logic [Op_Width-1:0] RESULT_HI,
    output logic                OUT_VALID,
    output logic                Carry_FLAG,
    output logic                Zero_FLAG,
    output logic                Neg_FLAG,
    output logic                Ovf_FLAG,
    output logic                Div0_FLAG
);
    localparam int W = Op_Width;
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100, OP_OR  = 4'b0101, OP_NAND = 4'b0110, OP_NOR = 4'b0111;
    localparam logic [3:0] OP_NOP = 4'b1000, OP_EQ  = 4'b1001, OP_GT  = 4'b1010, OP_LT  = 4'b1011;
    localparam logic [3:0] OP_SRL = 4'b1100, OP_SLL = 4'b1101, OP_SRA = 4'b1110, OP_ROL = 4'b1111;
    localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
    localparam logic [Sh_Width-1:0] CNT_INIT = Sh_Width'(W - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_MUL = 2'b01, ST_DIV = 2'b10} state_t;

    state_t              state_r, state_nx_s;
    logic                in_ready_r, out_valid_r;
    logic [W-1:0]        result_r, result_hi_r;
    logic                carry_r, zero_r, neg_r, ovf_r, div0_r;
    logic [W-1:0]        op_a_r, op_b_r, work_hi_r, work_lo_r;
    logic [Sh_Width-1:0] cnt_r;

    logic                accept_s, ld_s, ld_mul_s, step_en_s;
    logic                wr_en_s, wr_carry_s, wr_ovf_s, wr_div0_s;
    logic [W-1:0]        wr_res_s, wr_hi_s;
    logic [W-1:0]        sc_res_s, step_hi_s, step_lo_s;
    logic                sc_carry_s, sc_ovf_s;
    logic [W:0]          sum_s, diff_s, mul_sum_s, div_rs_s, div_diff_s;
    logic [2*W-1:0]      rol_s;
    logic [Sh_Width-1:0] sh_s;

    assign accept_s = IN_VALID && in_ready_r;
    assign sh_s     = B[Sh_Width-1:0];

    // Single-cycle datapath evaluated on the live operands
    always_comb begin
        sc_res_s   = '0;
        sc_carry_s = 1'b0;
        sc_ovf_s   = 1'b0;
        sum_s      = {1'b0, A} + {1'b0, B};
        diff_s     = {1'b0, A} - {1'b0, B};
        rol_s      = {A, A} << sh_s;
        case (ALU_FUN)
            OP_ADD: begin
                sc_res_s   = sum_s[W-1:0];
                sc_carry_s = sum_s[W];
                sc_ovf_s   = (A[W-1] == B[W-1]) && (sum_s[W-1] != A[W-1]);
            end
            OP_SUB: begin
                sc_res_s   = diff_s[W-1:0];
                sc_carry_s = diff_s[W];
                sc_ovf_s   = (A[W-1] != B[W-1]) && (diff_s[W-1] != A[W-1]);
            end
            OP_AND:  sc_res_s = A & B;
            OP_OR:   sc_res_s = A | B;
            OP_NAND: sc_res_s = ~(A & B);
            OP_NOR:  sc_res_s = ~(A | B);
            OP_EQ:   sc_res_s = (A == B) ? ONE_W : '0;
            OP_GT:   sc_res_s = (A > B) ? ONE_W : '0;
            OP_LT:   sc_res_s = (A < B) ? ONE_W : '0;
            OP_SRL:  sc_res_s = A >> sh_s;
            OP_SLL:  sc_res_s = A << sh_s;
            OP_SRA:  sc_res_s = W'($signed(A) >>> sh_s);
            OP_ROL:  sc_res_s = rol_s[2*W-1:W];
            default: sc_res_s = '0;
        endcase
    end

    // One iteration step: LSB-first shift-add for MUL, restoring subtract for DIV
    always_comb begin
        mul_sum_s  = {1'b0, work_hi_r} + {1'b0, op_a_r};
        div_rs_s   = {work_hi_r, work_lo_r[W-1]};
        div_diff_s = div_rs_s - {1'b0, op_b_r};
        step_hi_s  = work_hi_r;
        step_lo_s  = work_lo_r;
        if (state_r == ST_MUL) begin
            if (work_lo_r[0]) begin
                step_hi_s = mul_sum_s[W:1];
                step_lo_s = {mul_sum_s[0], work_lo_r[W-1:1]};
            end else begin
                step_hi_s = {1'b0, work_hi_r[W-1:1]};
                step_lo_s = {work_hi_r[0], work_lo_r[W-1:1]};
            end
        end else if (div_diff_s[W]) begin
            step_hi_s = div_rs_s[W-1:0];
            step_lo_s = {work_lo_r[W-2:0], 1'b0};
        end else begin
            step_hi_s = div_diff_s[W-1:0];
            step_lo_s = {work_lo_r[W-2:0], 1'b1};
        end
    end

    // Next-state and result-write decode
    always_comb begin
        state_nx_s = state_r;
        ld_s       = 1'b0;
        ld_mul_s   = 1'b0;
        step_en_s  = 1'b0;
        wr_en_s    = 1'b0;
        wr_res_s   = '0;
        wr_hi_s    = '0;
        wr_carry_s = 1'b0;
        wr_ovf_s   = 1'b0;
        wr_div0_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nx_s = ST_IDLE;
                end else if (ALU_FUN == OP_MUL) begin
                    state_nx_s = ST_MUL;
                    ld_s       = 1'b1;
                    ld_mul_s   = 1'b1;
                end else if (ALU_FUN == OP_DIV && B != '0) begin
                    state_nx_s = ST_DIV;
                    ld_s       = 1'b1;
                end else if (ALU_FUN == OP_DIV) begin
                    // Divide by zero short-circuits like a single-cycle op
                    wr_en_s   = 1'b1;
                    wr_res_s  = '1;
                    wr_hi_s   = A;
                    wr_div0_s = 1'b1;
                end else begin
                    wr_en_s    = 1'b1;
                    wr_res_s   = sc_res_s;
                    wr_carry_s = sc_carry_s;
                    wr_ovf_s   = sc_ovf_s;
                end
            end
            ST_MUL, ST_DIV: begin
                step_en_s = 1'b1;
                if (cnt_r == '0) begin
                    state_nx_s = ST_IDLE;
                    wr_en_s    = 1'b1;
                    wr_res_s   = step_lo_s;
                    wr_hi_s    = step_hi_s;
                    wr_ovf_s   = (state_r == ST_MUL) && (step_hi_s != '0);
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, operand latches and iteration registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            op_a_r    <= '0;
            op_b_r    <= '0;
            work_hi_r <= '0;
            work_lo_r <= '0;
            cnt_r     <= '0;
        end else begin
            state_r <= state_nx_s;
            if (ld_s) begin
                op_a_r    <= A;
                op_b_r    <= B;
                work_hi_r <= '0;
                work_lo_r <= ld_mul_s ? B : A;
                cnt_r     <= CNT_INIT;
            end else if (step_en_s) begin
                work_hi_r <= step_hi_s;
                work_lo_r <= step_lo_s;
                cnt_r     <= cnt_r - Sh_Width'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Registered outputs; results and flags hold until the next write
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            result_hi_r <= '0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
            div0_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= wr_en_s;
            if (wr_en_s) begin
                result_r    <= wr_res_s;
                result_hi_r <= wr_hi_s;
                carry_r     <= wr_carry_s;
                zero_r      <= (wr_res_s == '0);
                neg_r       <= wr_res_s[W-1];
                ovf_r       <= wr_ovf_s;
                div0_r      <= wr_div0_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign IN_READY   = in_ready_r;
    assign OUT_VALID  = out_valid_r;
    assign RESULT     = result_r;
    assign RESULT_HI  = result_hi_r;
    assign Carry_FLAG = carry_r;
    assign Zero_FLAG  = zero_r;
    assign Neg_FLAG   = neg_r;
    assign Ovf_FLAG   = ovf_r;
    assign Div0_FLAG  = div0_r;
endmodule
